// File: rtl/pc_fetch_unit.sv
// Program counter plus single-outstanding instruction fetch with a valid/ready
// handoff to decode, stall back-pressure and branch-redirect flushing.
module pc_fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_next,
   input  logic            redirect,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic            misalign
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic            discard_reg, discard_next;
   logic [31:0]     instr_reg, instr_next;
   logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
   logic            instr_valid_reg, instr_valid_next;
   logic            misalign_reg, misalign_next;
   logic            load_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         fetch_pc_reg    <= RESET_ADDR;
         discard_reg     <= 1'b0;
         instr_reg       <= NOP;
         instr_pc_reg    <= RESET_ADDR;
         instr_valid_reg <= 1'b0;
         misalign_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         discard_reg     <= discard_next;
         instr_reg       <= instr_next;
         instr_pc_reg    <= instr_pc_next;
         instr_valid_reg <= instr_valid_next;
         misalign_reg    <= misalign_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = fetch_pc_reg;
      discard_next     = discard_reg;
      instr_next       = instr_reg;
      instr_pc_next    = instr_pc_reg;
      instr_valid_next = instr_valid_reg;
      misalign_next    = 1'b0;
      load_pc          = 1'b0;

      unique case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            // A grant coinciding with a redirect still belongs to the old address
            if (imem_gnt) begin
               state_next = WAIT;
               if (redirect) discard_next = 1'b1;
            end
            if (redirect) load_pc = 1'b1;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (discard_reg || redirect) begin
                  discard_next = 1'b0;
                  state_next   = REQ;
               end else begin
                  instr_next       = imem_rdata;
                  instr_pc_next    = fetch_pc_reg;
                  instr_valid_next = 1'b1;
                  state_next       = HOLD;
               end
            end else if (redirect) begin
               discard_next = 1'b1;
            end
            if (redirect) load_pc = 1'b1;
         end
         HOLD: begin
            if (redirect || (instr_ready && !stall)) begin
               load_pc    = 1'b1;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase

      // Every PC load forces word alignment and flags a dropped low-bit offset
      if (load_pc) begin
         fetch_pc_next    = {pc_next[XLEN-1:2], 2'b00};
         misalign_next    = |pc_next[1:0];
         instr_valid_next = 1'b0;
      end
   end

   assign pc          = fetch_pc_reg;
   assign pc_plus4    = fetch_pc_reg + XLEN'(4);
   assign imem_req    = (state_reg == REQ);
   assign imem_addr   = fetch_pc_reg;
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = instr_valid_reg;
   assign misalign    = misalign_reg;

endmodule
